cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have ports, in order: clk in 1 (single clock, all state on rising edge); rst in 1 (synchronous, active-high).
REQ-002 SHALL have I-side ports: icache_pmem_address in 16 (lc3b_word); icache_pmem_read in 1; icache_pmem_write in 1; icache_pmem_wdata in 128 (lc3b_memband); icache_pmem_rdata out 128; icache_pmem_resp out 1.
REQ-003 SHALL have D-side ports: dcache_pmem_address in 16; dcache_pmem_read in 1; dcache_pmem_write in 1; dcache_pmem_wdata in 128; dcache_pmem_rdata out 128; dcache_pmem_resp out 1.
REQ-004 SHALL have memory-side ports: pmem_address out 16; pmem_read out 1; pmem_write out 1; pmem_wdata out 128; pmem_rdata in 128; pmem_resp in 1.

Function
REQ-005 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, plus a 1-bit last_grant register (0=I, 1=D).
REQ-006 IDLE: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, both client resp=0.
REQ-007 IDLE, only I requesting (read|write): next state GRANT_I; only D requesting: GRANT_D; none: stay IDLE.
REQ-008 IDLE, both requesting: grant the client not equal to last_grant (round-robin); last_grant updates on entry to any GRANT state.
REQ-009 GRANT_x: pmem_address/read/write/wdata SHALL equal the granted client's inputs combinationally; the other client's inputs SHALL be ignored.
REQ-010 GRANT_x: pmem_resp SHALL route to the granted client's resp only; non-granted resp SHALL be 0 in all states.
REQ-011 pmem_rdata SHALL be driven unchanged to both icache_pmem_rdata and dcache_pmem_rdata in all states.
REQ-012 GRANT_x with pmem_resp=1: next state IDLE (one-cycle resp pulse passes through, no repeat).
REQ-013 GRANT_x with granted client read=0 and write=0 and pmem_resp=0 (request withdrawn): next state IDLE; pmem read/write already 0 that cycle.
REQ-014 Arbitration latency: exactly one cycle from request assertion in IDLE to pmem_read/pmem_write assertion.
REQ-015 Back-to-back requests (e.g. dirty write-back then line fill) SHALL each arbitrate separately through IDLE; a waiting other client wins the next arbitration.
REQ-016 Client read and write both high: forwarded unchanged; behaviour of the memory is outside this block.
REQ-017 pmem_resp in IDLE SHALL be ignored (no client resp).

Reset
REQ-018 rst=1 at a clock edge: state=IDLE, last_grant=1 (so I wins the first tie); outputs per REQ-006 from the next cycle.
REQ-019 rst mid-grant SHALL abandon the transaction; no resp delivered to either client for it.

Structure
REQ-020 lc3b_word and lc3b_memband SHALL come from the shared lc3b_types package; the state enum SHALL stay local to the module.
REQ-021 No sub-module; FSM next-state, output mux and last_grant register live in cache_arbiter (sized for roughly 120-200 lines).
REQ-022 The cache top level SHALL instantiate two caches and one cache_arbiter between them and physical memory.

Verification
REQ-023 I read 0x1230 alone -> IDLE 1 cycle, then pmem_read=1, pmem_address=0x1230; memory resp with rdata=0xDEAD...BEEF -> icache_pmem_resp=1 one cycle, dcache_pmem_resp=0, state IDLE next.
REQ-024 After reset, I read 0x0100 and D write 0x2000 same cycle -> I granted first; after its resp, D granted with pmem_write=1, pmem_address=0x2000, pmem_wdata=D wdata.
REQ-025 Alternating simultaneous requests for 4 rounds -> grants I,D,I,D.
REQ-026 D write-back 0x4000 then immediately D read 0x4000 while I waits on 0x0200 -> order D-write, I-read, D-read.
REQ-027 rst asserted during GRANT_D with memory resp pending -> next cycle IDLE, pmem_read=pmem_write=0, no dcache_pmem_resp.
REQ-028 Granted I drops read before resp -> IDLE next cycle; pending D request granted the cycle after.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types used by the caches and the arbiter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_memband;

endpackage : lc3b_types

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that lets the I-cache and D-cache share one physical memory port.
// A grant lasts for one memory transaction and always returns through IDLE.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,

  input  lc3b_word    icache_pmem_address,
  input  logic        icache_pmem_read,
  input  logic        icache_pmem_write,
  input  lc3b_memband icache_pmem_wdata,
  output lc3b_memband icache_pmem_rdata,
  output logic        icache_pmem_resp,

  input  lc3b_word    dcache_pmem_address,
  input  logic        dcache_pmem_read,
  input  logic        dcache_pmem_write,
  input  lc3b_memband dcache_pmem_wdata,
  output lc3b_memband dcache_pmem_rdata,
  output logic        dcache_pmem_resp,

  output lc3b_word    pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output lc3b_memband pmem_wdata,
  input  lc3b_memband pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // 0 = I-cache, 1 = D-cache
  logic   i_req;
  logic   d_req;

  assign i_req = icache_pmem_read | icache_pmem_write;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || last_grant)) begin
            state      <= GRANT_I;
            last_grant <= 1'b0;
          end else if (d_req) begin
            state      <= GRANT_D;
            last_grant <= 1'b1;
          end
        end
        GRANT_I: if (pmem_resp || !i_req) state <= IDLE;
        GRANT_D: if (pmem_resp || !d_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is a plain broadcast; only the resp strobe tells a cache it is for it.
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

  always_comb begin
    pmem_address     = '0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_wdata       = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state)
      GRANT_I: begin
        pmem_address     = icache_pmem_address;
        pmem_read        = icache_pmem_read;
        pmem_write       = icache_pmem_write;
        pmem_wdata       = icache_pmem_wdata;
        icache_pmem_resp = pmem_resp & ~rst;
      end
      GRANT_D: begin
        pmem_address     = dcache_pmem_address;
        pmem_read        = dcache_pmem_read;
        pmem_write       = dcache_pmem_write;
        pmem_wdata       = dcache_pmem_wdata;
        // A reset in the grant cycle abandons the transaction, so suppress the resp.
        dcache_pmem_resp = pmem_resp & ~rst;
      end
      default: ;
    endcase
  end

endmodule : cache_arbiter
